fetch_unit: RTL and testbench

Instruction fetch stage with a small prefetch queue, sitting directly upstream of the IF/ID pipeline register. It owns the program counter, issues single-outstanding req/ack reads to a variable-latency instruction memory, and buffers fetched words with their PC+4. It presents one instruction per cycle to IF/ID, honours hazard stalls, and flushes on branch/jump redirects.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int              PC_W             = 32;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0] inst;
        logic [PC_W-1:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {inst, pc_plus4}; first-word-fall-through head, flush drops all entries.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem reads, feeds IF/ID from a prefetch queue.
// Optional FETCH_BYPASS_EN: an acked word goes straight to IF/ID when the queue is empty and IF/ID accepts.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [PC_W-1:0] inst,
    output logic [PC_W-1:0] pc_plus4
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] imem_addr_q, imem_addr_d;
    logic            imem_req_q, imem_req_d;

    logic [CW-1:0]   count, count_next;
    logic [PC_W-1:0] fetch_pc_plus4;
    logic            wait_ack, fifo_valid, fifo_push, fifo_pop;
    fetch_entry_t    head, wentry;

    assign fetch_pc_plus4 = fetch_pc_q + 32'd4;
    assign wait_ack       = (state_q == WAIT) && imem_ack;
    assign fifo_valid     = (count != '0);
    assign fifo_pop       = fifo_valid && !stall && !redirect;
    assign wentry         = '{inst: imem_rdata, pc_plus4: fetch_pc_plus4};

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass    = wait_ack && !fifo_valid && !stall && !redirect;
    assign fifo_push = wait_ack && !redirect && !bypass;
`else
    assign fifo_push = wait_ack && !redirect;
`endif

    // Occupancy after this cycle's push/pop; a new request is only issued if a slot stays free.
    assign count_next = count + CW'(fifo_push) - CW'(fifo_pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: begin
                if (redirect || count_next < CW'(DEPTH)) state_d = WAIT;
            end
            WAIT: begin
                if (imem_ack) state_d = (redirect || count_next < CW'(DEPTH)) ? WAIT : IDLE;
                else if (redirect) state_d = DROP;
            end
            DROP: begin
                if (imem_ack) state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase

        if (redirect)      fetch_pc_d = redirect_pc;
        else if (wait_ack) fetch_pc_d = fetch_pc_plus4;

        imem_req_d = (state_d != IDLE);
        // The stale request keeps its address until memory acks it.
        imem_addr_d = (state_d == DROP) ? imem_addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_addr_q <= RESET_PC;
            imem_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_addr_q <= imem_addr_d;
            imem_req_q  <= imem_req_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect),
        .wdata (wentry),
        .head  (head),
        .count (count)
    );

    always_comb begin
        inst_valid = fifo_valid;
        inst       = fifo_valid ? head.inst     : '0;
        pc_plus4   = fifo_valid ? head.pc_plus4 : '0;
`ifdef FETCH_BYPASS_EN
        if (bypass) begin
            inst_valid = 1'b1;
            inst       = imem_rdata;
            pc_plus4   = fetch_pc_plus4;
        end
`endif
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit: variable-latency memory model and an in-order delivery model.
module tb_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, pc_plus4;

    int          compared = 0;
    int          mismatched = 0;
    int          mem_lat = 0;
    bit          mem_rand = 1'b0;
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    int          m_lat_cur = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] exp_pc = RESET_PC;
    int          pops = 0;
    int          p0 = 0;
    int unsigned rr = 0;
    logic        rst_v = 1'b0;
    logic [31:0] tgt = '0;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .pc_plus4    (pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs and memory response after the edge, then sample at the falling edge.
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic st);
        @(posedge clk);
        #1;
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        stall       = st;
        if (!imem_req) begin
            imem_ack = 1'b0;
            m_busy   = 1'b0;
        end else begin
            if (!m_busy) begin
                m_busy    = 1'b1;
                m_wait    = 0;
                m_lat_cur = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
                m_addr    = imem_addr;
            end else begin
                chk("addr_stable", imem_addr, m_addr);
            end
            if (m_wait >= m_lat_cur) begin
                imem_ack   = 1'b1;
                imem_rdata = mw(imem_addr);
                m_busy     = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                m_wait++;
            end
        end
        @(negedge clk);
        // Delivered stream must be consecutive words from the last reset/redirect target.
        if (r) exp_pc = RESET_PC;
        else if (rd) exp_pc = rpc;
        else if (inst_valid && !st) begin
            chk("pop_pc_plus4", pc_plus4, exp_pc + 32'd4);
            chk("pop_inst", inst, mw(exp_pc));
            exp_pc += 32'd4;
            pops++;
        end
    endtask

    initial begin
        // Reset values
        step(1'b1, 1'b0, '0, 1'b0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc4", pc_plus4, 32'd0);

        // Zero-wait streaming from RESET_PC
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t1_c0_req", 32'(imem_req), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            chk("t1_req", 32'(imem_req), 32'd1);
            chk("t1_addr", imem_addr, 32'(4 * (k - 1)));
            chk("t1_valid", 32'(inst_valid), 32'(k >= 1 + LAT));
            if (k >= 1 + LAT) begin
                chk("t1_pc4", pc_plus4, 32'(4 * (k - LAT)));
                chk("t1_inst", inst, mw(32'(4 * (k - LAT) - 4)));
            end
        end

        // Stall fills the queue, then releases
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        repeat (4) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("t2_full_req", 32'(imem_req), 32'd0);
        chk("t2_full_addr", imem_addr, 32'h10);
        chk("t2_full_valid", 32'(inst_valid), 32'd1);
        chk("t2_head_pc4", pc_plus4, 32'h4);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("t2_hold_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t2_resume_req", 32'(imem_req), 32'd1);
        chk("t2_resume_addr", imem_addr, 32'h10);
        repeat (6) step(1'b0, 1'b0, '0, 1'b0);

        // Redirect while a slow request is pending
        mem_lat = 3;
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'h100, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t3_drop_req", 32'(imem_req), 32'd1);
        chk("t3_drop_addr", imem_addr, 32'h0);
        chk("t3_drop_valid", 32'(inst_valid), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t3_ack_valid", 32'(inst_valid), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t3_new_addr", imem_addr, 32'h100);
        chk("t3_new_valid", 32'(inst_valid), 32'd0);
        for (int c = 6; c <= 7 + LAT; c++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            chk("t3_wait_valid", 32'(inst_valid), 32'd0);
        end
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t3_first_valid", 32'(inst_valid), 32'd1);
        chk("t3_first_pc4", pc_plus4, 32'h104);

        // Redirect in the same cycle as the ack
        mem_lat = 1;
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'h200, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t4_req", 32'(imem_req), 32'd1);
        chk("t4_addr", imem_addr, 32'h200);
        chk("t4_empty", 32'(inst_valid), 32'd0);
        repeat (1 + LAT) step(1'b0, 1'b0, '0, 1'b0);
        chk("t4_first_valid", 32'(inst_valid), 32'd1);
        chk("t4_first_pc4", pc_plus4, 32'h204);

        // Reset pulse while a request is outstanding and the queue holds a word
        mem_lat = 2;
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        repeat (4) step(1'b0, 1'b0, '0, 1'b1);
        chk("t5_pre_req", 32'(imem_req), 32'd1);
        chk("t5_pre_valid", 32'(inst_valid), 32'd1);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t5_req", 32'(imem_req), 32'd0);
        chk("t5_valid", 32'(inst_valid), 32'd0);
        chk("t5_addr", imem_addr, RESET_PC);
        chk("t5_pc4", pc_plus4, 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t5_restart_req", 32'(imem_req), 32'd1);
        chk("t5_restart_addr", imem_addr, RESET_PC);
        repeat (8) step(1'b0, 1'b0, '0, 1'b0);

        // PC wrap past the top of the address space
        mem_lat = 0;
        p0 = pops;
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        repeat (8) step(1'b0, 1'b0, '0, 1'b0);
        chk("wrap_progress", 32'(pops - p0 >= 4), 32'd1);

        // Randomized latency, stalls, redirects and occasional resets
        mem_rand = 1'b1;
        p0 = pops;
        for (int i = 0; i < 3000; i++) begin
            rr    = $urandom_range(0, 99);
            rst_v = ($urandom_range(0, 99) < 30);
            if (rr < 1) begin
                step(1'b1, 1'b0, '0, rst_v);
            end else if (rr < 6) begin
                tgt = $urandom & 32'hFFFF_FFFC;
                if (rr == 5) tgt = 32'hFFFF_FFF4;
                step(1'b0, 1'b1, tgt, rst_v);
            end else begin
                step(1'b0, 1'b0, '0, rst_v);
            end
        end
        chk("rand_progress", 32'(pops - p0 > 300), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
